// File: rtl/sensor_cond_pkg.sv
// Shared types and build-time derivations for the sensor conditioning block.
package sensor_cond_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_W         = 12;
  localparam int DEF_AVG_SHIFT = 5;
  localparam int DEF_CAD_MASK  = 1;
  localparam int DEF_FAST_SIM  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Clocks the synchronised cadence level must hold before the filter follows it.
  function automatic int deb_of(input int fast_sim);
    return (fast_sim != 0) ? 16 : 1024;
  endfunction

  function automatic int per_w_of(input int fast_sim);
    return (fast_sim != 0) ? 16 : 24;
  endfunction

endpackage

// File: rtl/sensor_cond_mc_cadence_filt.sv
// Cadence input conditioning: synchroniser, debounce, rise detect and period measurement.
module cadence_filt
  import sensor_cond_pkg::*;
#(
  parameter int FAST_SIM = DEF_FAST_SIM
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cadence_raw,
  output logic                          cad_rise,
  output logic [per_w_of(FAST_SIM)-1:0] cadence_per,
  output logic                          not_pedaling
);

  localparam int DEB   = deb_of(FAST_SIM);
  localparam int PER_W = per_w_of(FAST_SIM);
  localparam int DW    = $clog2(DEB);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);

  logic             sync1;
  logic             sync2;
  logic             filt;
  logic [DW-1:0]    deb_cnt;
  logic [PER_W-1:0] per_cnt;
  logic             accept;

  // The synchronised level has differed from the filter for DEB clocks in a row.
  assign accept = (sync2 != filt) && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= cadence_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt     <= 1'b0;
      deb_cnt  <= '0;
      cad_rise <= 1'b0;
    end else begin
      cad_rise <= accept && sync2;
      if (sync2 == filt) begin
        deb_cnt <= '0;
      end else if (accept) begin
        filt    <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Counter starts saturated so the block reads as stopped until a real rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt     <= '1;
      cadence_per <= '0;
    end else if (cad_rise) begin
      cadence_per <= per_cnt;
      per_cnt     <= PER_W'(1);
    end else if (per_cnt != '1) begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  assign not_pedaling = (per_cnt == '1) && !cad_rise;

endmodule

// File: rtl/sensor_cond_mc.sv
// Multi-channel sensor conditioner: event-driven snapshots averaged by one shared EMA datapath.
module sensor_cond_mc
  import sensor_cond_pkg::*;
#(
  parameter int                NUM_CH    = DEF_NUM_CH,
  parameter int                W         = DEF_W,
  parameter int                AVG_SHIFT = DEF_AVG_SHIFT,
  parameter logic [NUM_CH-1:0] CAD_MASK  = NUM_CH'(DEF_CAD_MASK),
  parameter int                FAST_SIM  = DEF_FAST_SIM
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cadence_raw,
  input  logic [NUM_CH*W-1:0]           sample,
  input  logic                          sample_vld,
  output logic [NUM_CH*W-1:0]           avg,
  output logic                          avg_vld,
  output logic [per_w_of(FAST_SIM)-1:0] cadence_per,
  output logic                          not_pedaling
);

  localparam int AW    = W + AVG_SHIFT;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  logic              cad_rise;
  state_t            state;
  state_t            state_n;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;
  logic [NUM_CH-1:0] pending;
  logic [W-1:0]      snap [NUM_CH];
  logic [AW-1:0]     acc  [NUM_CH];
  logic [AW-1:0]     cur_acc;
  logic [W-1:0]      cur_snap;
  logic [AW-1:0]     upd_acc;

  cadence_filt #(
    .FAST_SIM (FAST_SIM)
  ) u_filt (
    .clk          (clk),
    .rst_n        (rst_n),
    .cadence_raw  (cadence_raw),
    .cad_rise     (cad_rise),
    .cadence_per  (cadence_per),
    .not_pedaling (not_pedaling)
  );

  // A set in the same clock as the visit wins over the clear, so that event
  // keeps its new snapshot pending for the next pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (state == ST_SCAN && idx == IDX_W'(i)) pending[i] <= 1'b0;
        if ((cad_rise && CAD_MASK[i]) || (sample_vld && !CAD_MASK[i])) begin
          snap[i]    <= sample[i*W +: W];
          pending[i] <= 1'b1;
        end
      end
    end
  end

  // Shared EMA step; the accumulator holds avg scaled by 2^AVG_SHIFT, so full scale fits in AW bits.
  assign cur_acc  = acc[idx];
  assign cur_snap = snap[idx];
  assign upd_acc  = cur_acc - (cur_acc >> AVG_SHIFT) + AW'(cur_snap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else if (state == ST_SCAN && pending[idx]) begin
      acc[idx] <= upd_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    avg_vld = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          state_n = ST_SCAN;
          idx_n   = '0;
        end
      end
      ST_SCAN: begin
        if (idx == IDX_LAST) state_n = ST_DONE;
        else                 idx_n   = idx + IDX_W'(1);
      end
      ST_DONE: begin
        avg_vld = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_avg
    assign avg[g*W +: W] = W'(acc[g] >> AVG_SHIFT);
  end

endmodule

// File: tb/tb_sensor_cond_mc.sv
// Directed/random bench for sensor_cond_mc with an EMA reference model, FAST_SIM build.
module tb_sensor_cond_mc;

  localparam int NCH       = 4;
  localparam int W         = 12;
  localparam int SH        = 5;
  localparam int PER_W     = 16;
  localparam int RISE_LAT  = 18;  // 2 synchroniser flops + 16 stable debounce clocks
  localparam int PASS_MAX  = 2 * NCH + 2;
  localparam int HALF_PER  = 4096;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cadence_raw;
  logic [NCH*W-1:0]   sample;
  logic               sample_vld;
  logic [NCH*W-1:0]   avg;
  logic               avg_vld;
  logic [PER_W-1:0]   cadence_per;
  logic               not_pedaling;

  int                 total = 0;
  int                 bad = 0;
  int                 cyc = 0;
  int                 model_acc [NCH];
  logic [W-1:0]       smp [NCH];

  sensor_cond_mc #(
    .NUM_CH    (NCH),
    .W         (W),
    .AVG_SHIFT (SH),
    .CAD_MASK  (4'b0001),
    .FAST_SIM  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cadence_raw  (cadence_raw),
    .sample       (sample),
    .sample_vld   (sample_vld),
    .avg          (avg),
    .avg_vld      (avg_vld),
    .cadence_per  (cadence_per),
    .not_pedaling (not_pedaling)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_samples();
    for (int i = 0; i < NCH; i++) sample[i*W +: W] = smp[i];
  endtask

  task automatic model_update(input logic [NCH-1:0] mask);
    for (int i = 0; i < NCH; i++)
      if (mask[i]) model_acc[i] = model_acc[i] - (model_acc[i] / (1 << SH)) + int'(smp[i]);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) model_acc[i] = 0;
  endtask

  task automatic check_avg(input string tag);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("%s_avg%0d", tag, i), 32'(avg[i*W +: W]), 32'(model_acc[i] / (1 << SH)));
  endtask

  // Runs the full budget so a second, spurious pulse is also counted.
  task automatic wait_vld(input int budget, output int n_vld, output int lat);
    n_vld = 0;
    lat   = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (avg_vld === 1'b1) begin
        n_vld++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic strobe_event(input string tag, input int budget);
    int n;
    int lat;
    drive_samples();
    sample_vld = 1'b1;
    tick();
    sample_vld = 1'b0;
    model_update(4'b1110);
    wait_vld(budget, n, lat);
    chk({tag, "_vld_cnt"}, 32'(n), 32'd1);
    chk({tag, "_latency_ok"}, 32'(lat >= 1 && lat <= PASS_MAX), 32'd1);
    check_avg(tag);
  endtask

  initial begin
    int n;
    int lat;
    int stray;
    int t0;
    logic [W-1:0] prev_avg1;

    rst_n       = 1'b0;
    cadence_raw = 1'b0;
    sample      = '0;
    sample_vld  = 1'b0;
    model_clear();
    for (int i = 0; i < NCH; i++) smp[i] = '0;

    // Reset values, both while held and right after release.
    repeat (3) tick();
    chk("rst_avg", 32'(avg), 32'd0);
    chk("rst_avg_vld", 32'(avg_vld), 32'd0);
    chk("rst_cadence_per", 32'(cadence_per), 32'd0);
    chk("rst_not_pedaling", 32'(not_pedaling), 32'd1);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_avg_vld", 32'(avg_vld), 32'd0);
    chk("post_rst_not_pedaling", 32'(not_pedaling), 32'd1);
    chk("post_rst_cadence_per", 32'(cadence_per), 32'd0);

    // Channel 1 held at 0x3FF, strobed every 10 clocks: rises monotonically to the top.
    smp[1]    = 12'h3FF;
    prev_avg1 = '0;
    for (int s = 0; s < 300; s++) begin
      strobe_event("ramp", 9);
      chk("ramp_monotonic", 32'(avg[W +: W] >= prev_avg1), 32'd1);
      prev_avg1 = avg[W +: W];
    end
    chk("ramp_final_range", 32'(avg[W +: W] >= 12'h3FE && avg[W +: W] <= 12'h3FF), 32'd1);

    // Random samples on all channels; only the non-cadence channels may move.
    for (int e = 0; e < 20; e++) begin
      for (int i = 0; i < NCH; i++) smp[i] = W'($urandom_range(0, (1 << W) - 1));
      strobe_event("rand", PASS_MAX);
      repeat ($urandom_range(0, 5)) tick();
    end

    // Short glitches never pass the debounce.
    stray = 0;
    for (int g = 0; g < 3; g++) begin
      cadence_raw = 1'b1;
      repeat (3) tick();
      cadence_raw = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (avg_vld === 1'b1) stray++;
      end
    end
    chk("glitch_no_pass", 32'(stray), 32'd0);
    chk("glitch_cadence_per", 32'(cadence_per), 32'd0);
    chk("glitch_not_pedaling", 32'(not_pedaling), 32'd1);

    // First rise comes from the saturated counter.
    smp[0] = W'($urandom_range(0, (1 << W) - 1));
    drive_samples();
    cadence_raw = 1'b1;
    t0 = cyc;
    model_update(4'b0001);
    wait_vld(RISE_LAT + PASS_MAX + 4, n, lat);
    chk("rise1_vld_cnt", 32'(n), 32'd1);
    chk("rise1_cadence_per", 32'(cadence_per), 32'hFFFF);
    chk("rise1_not_pedaling", 32'(not_pedaling), 32'd0);
    check_avg("rise1");

    // Toggle every 4096 clocks; the falling edge must not start a pass.
    stray = 0;
    while (cyc - t0 < HALF_PER) begin
      tick();
      if (avg_vld === 1'b1) stray++;
    end
    cadence_raw = 1'b0;
    while (cyc - t0 < 2 * HALF_PER) begin
      tick();
      if (avg_vld === 1'b1) stray++;
    end
    chk("fall_no_pass", 32'(stray), 32'd0);
    chk("mid_period_not_pedaling", 32'(not_pedaling), 32'd0);

    // Second rise with sample_vld on the cad_rise clock: one pass updates every channel.
    smp[0] = 12'h2FF;
    for (int i = 1; i < NCH; i++) smp[i] = W'($urandom_range(0, (1 << W) - 1));
    drive_samples();
    cadence_raw = 1'b1;
    stray = 0;
    for (int k = 0; k < RISE_LAT; k++) begin
      tick();
      if (avg_vld === 1'b1) stray++;
    end
    sample_vld = 1'b1;
    tick();
    sample_vld = 1'b0;
    model_update(4'b1111);
    wait_vld(PASS_MAX + 2, n, lat);
    chk("rise2_no_early_pass", 32'(stray), 32'd0);
    chk("rise2_vld_cnt", 32'(n), 32'd1);
    chk("rise2_period_range",
        32'(cadence_per >= 16'd8191 && cadence_per <= 16'd8193), 32'd1);
    chk("rise2_not_pedaling", 32'(not_pedaling), 32'd0);
    check_avg("rise2");

    // Reset in the middle of a pass aborts it with no avg_vld.
    cadence_raw = 1'b0;
    repeat (30) tick();
    for (int i = 0; i < NCH; i++) smp[i] = W'($urandom_range(1, (1 << W) - 1));
    drive_samples();
    sample_vld = 1'b1;
    tick();
    sample_vld = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    chk("abort_avg_vld", 32'(avg_vld), 32'd0);
    chk("abort_avg", 32'(avg), 32'd0);
    chk("abort_cadence_per", 32'(cadence_per), 32'd0);
    chk("abort_not_pedaling", 32'(not_pedaling), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    model_clear();
    wait_vld(PASS_MAX + 4, n, lat);
    chk("abort_no_vld_after", 32'(n), 32'd0);
    check_avg("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
